// File: rtl/vending_pkg.sv
// Shared state encoding, coin values and product prices for the Lab4 vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CREDIT   = 2'd1,
    ST_DISPENSE = 2'd2,
    ST_CHANGE   = 2'd3
  } state_e;

  localparam int unsigned COIN100 = 32'd1;
  localparam int unsigned COIN500 = 32'd5;

  // Product prices in 100-unit steps, indexed by sel.
  localparam logic [3:0] PRICE [4] = '{4'd3, 4'd5, 4'd7, 4'd9};

  function automatic logic [3:0] price_of(input logic [1:0] sel);
    return PRICE[sel];
  endfunction

endpackage

// File: rtl/vending_controller_if.sv
// Coin/button inputs and credit/dispense outputs of the vending controller.
interface vending_controller_if #(
  parameter int BITS = 4
);

  logic            moneda100;
  logic            moneda500;
  logic [1:0]      sel;
  logic            buy;
  logic            cancel;
  logic [BITS-1:0] credit;
  logic            dispense;
  logic [1:0]      prod;
  logic            change;
  logic            coin_reject;
  logic            err;
  logic            busy;
  logic [6:0]      display;

  modport master (
    output moneda100, moneda500, sel, buy, cancel,
    input  credit, dispense, prod, change, coin_reject, err, busy, display
  );

  modport slave (
    input  moneda100, moneda500, sel, buy, cancel,
    output credit, dispense, prod, change, coin_reject, err, busy, display
  );

endinterface

// File: rtl/hex7seg.sv
// Combinational 4-bit to seven-segment decoder, active-low segments {g..a}.
module hex7seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Hex digit to segment pattern lookup.
  always_comb begin
    seg_o = 7'b1111111;
    case (hex_i)
      4'h0:    seg_o = 7'b1000000;
      4'h1:    seg_o = 7'b1111001;
      4'h2:    seg_o = 7'b0100100;
      4'h3:    seg_o = 7'b0110000;
      4'h4:    seg_o = 7'b0011001;
      4'h5:    seg_o = 7'b0010010;
      4'h6:    seg_o = 7'b0000010;
      4'h7:    seg_o = 7'b1111000;
      4'h8:    seg_o = 7'b0000000;
      4'h9:    seg_o = 7'b0010000;
      4'hA:    seg_o = 7'b0001000;
      4'hB:    seg_o = 7'b0000011;
      4'hC:    seg_o = 7'b1000110;
      4'hD:    seg_o = 7'b0100001;
      4'hE:    seg_o = 7'b0000110;
      4'hF:    seg_o = 7'b0001110;
      default: seg_o = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/vending_controller.sv
// Credit/purchase/change sequencer: edge-detects coins and buttons, keeps saturating
// credit, dispenses a product and pays back the remainder as spaced change pulses.
module vending_controller
  import vending_pkg::*;
#(
  parameter int BITS = 4
) (
  input  logic          clk,
  input  logic          rst,
  vending_controller_if.slave bus
);

  localparam logic [BITS-1:0] CREDIT_ZERO = {BITS{1'b0}};
  localparam logic [BITS-1:0] CREDIT_ONE  = {{(BITS-1){1'b0}}, 1'b1};
  localparam logic [BITS-1:0] CREDIT_MAX  = {BITS{1'b1}};
  localparam logic [BITS:0]   COIN100_W   = (BITS+1)'(COIN100);
  localparam logic [BITS:0]   COIN500_W   = (BITS+1)'(COIN500);

  state_e          state_q, state_d;
  logic [BITS-1:0] credit_q, credit_d;
  logic [1:0]      prod_q, prod_d;
  logic            dispense_q, dispense_d;
  logic            change_q, change_d;
  logic            reject_q, reject_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            m100_prev_q, m500_prev_q, buy_prev_q, cancel_prev_q;

  logic            m100_ev_s, m500_ev_s, buy_ev_s, cancel_ev_s, coin_any_s;
  logic [BITS:0]   sum100_s, sum500_s;
  logic            fit100_s, fit500_s;
  logic [3:0]      price_s;
  logic [BITS-1:0] price_w_s;
  logic            afford_s;

  assign m100_ev_s   = bus.moneda100 & ~m100_prev_q;
  assign m500_ev_s   = bus.moneda500 & ~m500_prev_q;
  assign buy_ev_s    = bus.buy       & ~buy_prev_q;
  assign cancel_ev_s = bus.cancel    & ~cancel_prev_q;
  assign coin_any_s  = m100_ev_s | m500_ev_s;

  // One spare bit so a saturating sum cannot wrap before the compare.
  assign sum100_s  = {1'b0, credit_q} + COIN100_W;
  assign sum500_s  = {1'b0, credit_q} + COIN500_W;
  assign fit100_s  = (sum100_s <= {1'b0, CREDIT_MAX});
  assign fit500_s  = (sum500_s <= {1'b0, CREDIT_MAX});
  assign price_s   = price_of(bus.sel);
  assign price_w_s = BITS'(price_s);
  assign afford_s  = ({1'b0, credit_q} >= (BITS+1)'(price_s));

  // Next-state and next-output decision for the sale sequence.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    prod_d     = prod_q;
    dispense_d = 1'b0;
    change_d   = 1'b0;
    reject_d   = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if ((state_q == ST_CREDIT) && cancel_ev_s) begin
          state_d  = ST_CHANGE;
          change_d = 1'b1;
          credit_d = credit_q - CREDIT_ONE;
          reject_d = coin_any_s;
        end else if ((state_q == ST_CREDIT) && buy_ev_s && afford_s) begin
          state_d    = ST_DISPENSE;
          credit_d   = credit_q - price_w_s;
          prod_d     = bus.sel;
          dispense_d = 1'b1;
          reject_d   = coin_any_s;
        end else begin
          err_d = buy_ev_s;
          // A 500 coin takes precedence; a simultaneous 100 is always refused.
          if (m500_ev_s) begin
            reject_d = m100_ev_s | ~fit500_s;
            if (fit500_s) begin
              credit_d = sum500_s[BITS-1:0];
              state_d  = ST_CREDIT;
            end else begin
              credit_d = credit_q;
            end
          end else if (m100_ev_s) begin
            reject_d = ~fit100_s;
            if (fit100_s) begin
              credit_d = sum100_s[BITS-1:0];
              state_d  = ST_CREDIT;
            end else begin
              credit_d = credit_q;
            end
          end else begin
            reject_d = 1'b0;
          end
        end
      end
      ST_DISPENSE: begin
        reject_d = coin_any_s;
        if (credit_q != CREDIT_ZERO) begin
          state_d  = ST_CHANGE;
          change_d = 1'b1;
          credit_d = credit_q - CREDIT_ONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHANGE: begin
        reject_d = coin_any_s;
        // change_q marks the emit half of the emit/gap alternation.
        if (change_q) begin
          if (credit_q == CREDIT_ZERO) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_CHANGE;
          end
        end else begin
          change_d = 1'b1;
          credit_d = credit_q - CREDIT_ONE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = CREDIT_ZERO;
      end
    endcase
    busy_d = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
  end

  // State, credit, registered outputs and input history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      credit_q      <= CREDIT_ZERO;
      prod_q        <= 2'd0;
      dispense_q    <= 1'b0;
      change_q      <= 1'b0;
      reject_q      <= 1'b0;
      err_q         <= 1'b0;
      busy_q        <= 1'b0;
      m100_prev_q   <= 1'b0;
      m500_prev_q   <= 1'b0;
      buy_prev_q    <= 1'b0;
      cancel_prev_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      prod_q        <= prod_d;
      dispense_q    <= dispense_d;
      change_q      <= change_d;
      reject_q      <= reject_d;
      err_q         <= err_d;
      busy_q        <= busy_d;
      m100_prev_q   <= bus.moneda100;
      m500_prev_q   <= bus.moneda500;
      buy_prev_q    <= bus.buy;
      cancel_prev_q <= bus.cancel;
    end
  end

  assign bus.credit      = credit_q;
  assign bus.prod        = prod_q;
  assign bus.dispense    = dispense_q;
  assign bus.change      = change_q;
  assign bus.coin_reject = reject_q;
  assign bus.err         = err_q;
  assign bus.busy        = busy_q;

  hex7seg u_hex7seg (
    .hex_i (4'(credit_q)),
    .seg_o (bus.display)
  );

endmodule

// File: tb/tb_vending_controller.sv
// Scoreboard bench: a timeline-based sale model predicts every cycle's outputs,
// a monitor process compares them against the controller one cycle later.
module tb_vending_controller;

  typedef struct {
    int   credit;
    int   prod;
    logic dispense;
    logic change;
    logic reject;
    logic err;
    logic busy;
  } exp_t;

  localparam int         MAXC = 15;
  localparam int         PRICES [4] = '{3, 5, 7, 9};
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic running;

  exp_t exp_q [$];
  exp_t tl [$];
  exp_t cur_e;
  logic p100, p500, pbuy, pcan;

  vending_controller_if #(.BITS(4)) bus ();

  vending_controller #(.BITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
    end
  endtask

  function automatic exp_t blank(input int cr, input int pd);
    exp_t e;
    e.credit = cr; e.prod = pd; e.dispense = 1'b0; e.change = 1'b0;
    e.reject = 1'b0; e.err = 1'b0; e.busy = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    cur_e = blank(0, 0);
    tl.delete();
    exp_q.delete();
    p100 = 1'b0; p500 = 1'b0; pbuy = 1'b0; pcan = 1'b0;
  endtask

  // n coins paid back: emit cycles interleaved with gap cycles, credit falling per emit.
  task automatic plan_change(input int n, input int pd);
    exp_t e;
    for (int i = 1; i <= n; i++) begin
      e = blank(n - i, pd); e.busy = 1'b1; e.change = 1'b1;
      tl.push_back(e);
      if (i < n) begin
        e = blank(n - i, pd); e.busy = 1'b1;
        tl.push_back(e);
      end
    end
  endtask

  task automatic model_step(input logic m1, input logic m5, input int s, input logic b, input logic c);
    logic e1, e5, eb, ec;
    int   cr;
    exp_t nx;
    e1 = m1 && !p100; e5 = m5 && !p500; eb = b && !pbuy; ec = c && !pcan;
    p100 = m1; p500 = m5; pbuy = b; pcan = c;
    cr = cur_e.credit;
    nx = blank(cr, cur_e.prod);
    if (cur_e.busy) begin
      if (tl.size() > 0) nx = tl.pop_front();
      nx.reject = e1 || e5;
    end else if (cr > 0 && ec) begin
      plan_change(cr, cur_e.prod);
      nx = tl.pop_front();
      nx.reject = e1 || e5;
    end else if (cr > 0 && eb && cr >= PRICES[s]) begin
      nx = blank(cr - PRICES[s], s);
      nx.dispense = 1'b1; nx.busy = 1'b1;
      plan_change(cr - PRICES[s], s);
      nx.reject = e1 || e5;
    end else begin
      nx.err = eb;
      if (e5) begin
        if (cr + 5 <= MAXC) cr = cr + 5; else nx.reject = 1'b1;
        if (e1) nx.reject = 1'b1;
      end else if (e1) begin
        if (cr + 1 <= MAXC) cr = cr + 1; else nx.reject = 1'b1;
      end
      nx.credit = cr;
    end
    cur_e = nx;
    exp_q.push_back(nx);
  endtask

  // Drive one cycle of inputs at the falling edge and predict the next state.
  task automatic cyc(input logic m1, input logic m5, input int s, input logic b, input logic c);
    bus.moneda100 = m1; bus.moneda500 = m5; bus.sel = 2'(s); bus.buy = b; bus.cancel = c;
    model_step(m1, m5, s, b, c);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_credit"}, int'(bus.credit), 0);
    chk({tag, "_pulses"}, int'({bus.dispense, bus.change, bus.coin_reject, bus.err, bus.busy}), 0);
    chk({tag, "_prod"}, int'(bus.prod), 0);
    chk({tag, "_display"}, int'(bus.display), int'(7'b1000000));
  endtask

  task automatic do_reset();
    bus.moneda100 = 1'b0; bus.moneda500 = 1'b0; bus.sel = 2'd0; bus.buy = 1'b0; bus.cancel = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    exp_t e;
    logic [6:0] seg_exp;
    n_checks = 0; n_fail = 0; running = 1'b0;
    rst = 1'b0;
    bus.moneda100 = 1'b0; bus.moneda500 = 1'b0; bus.sel = 2'd0; bus.buy = 1'b0; bus.cancel = 1'b0;
    model_reset();

    fork
      forever begin
        @(posedge clk);
        #1;
        if (rst && running) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_underflow at %0t: got no prediction, expected one", $time);
          end else begin
            e = exp_q.pop_front();
            seg_exp = SEG_TAB[e.credit];
            if (int'(bus.credit) != e.credit || int'(bus.prod) != e.prod ||
                bus.dispense !== e.dispense || bus.change !== e.change ||
                bus.coin_reject !== e.reject || bus.err !== e.err ||
                bus.busy !== e.busy || bus.display !== seg_exp) begin
              n_fail++;
              $display("FAIL cycle_outputs at %0t: got cr=%0d prod=%0d disp=%b chg=%b rej=%b err=%b busy=%b seg=%b, expected cr=%0d prod=%0d disp=%b chg=%b rej=%b err=%b busy=%b seg=%b",
                       $time, bus.credit, bus.prod, bus.dispense, bus.change, bus.coin_reject,
                       bus.err, bus.busy, bus.display, e.credit, e.prod, e.dispense, e.change,
                       e.reject, e.err, e.busy, seg_exp);
            end
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    running = 1'b1;

    // Three separate 100 coins.
    for (int i = 0; i < 3; i++) begin cyc(1'b1, 1'b0, 0, 1'b0, 1'b0); idle(1); end
    chk("three_coins_credit", int'(bus.credit), 3);
    chk("three_coins_display", int'(bus.display), int'(7'b0110000));

    // Saturation: 3 -> 8 -> 11, 500 refused, 100 x4 -> 15, fifth refused.
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b0); idle(1);
    for (int i = 0; i < 3; i++) begin cyc(1'b1, 1'b0, 0, 1'b0, 1'b0); idle(1); end
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b0); idle(1);
    for (int i = 0; i < 5; i++) begin cyc(1'b1, 1'b0, 0, 1'b0, 1'b0); idle(1); end
    chk("saturated_credit", int'(bus.credit), 15);

    // Cancel back to zero, then buy product 1 from credit 10.
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b1); idle(34);
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b0); idle(1); cyc(1'b0, 1'b1, 0, 1'b0, 1'b0); idle(1);
    cyc(1'b0, 1'b0, 1, 1'b1, 1'b0);
    chk("buy_dispense", int'(bus.dispense), 1);
    idle(12);

    // Insufficient credit.
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0); idle(1); cyc(1'b1, 1'b0, 0, 1'b0, 1'b0); idle(1);
    cyc(1'b0, 1'b0, 3, 1'b1, 1'b0);
    chk("insufficient_err", int'(bus.err), 1);
    idle(2); cyc(1'b0, 1'b0, 0, 1'b0, 1'b1); idle(6);

    // Simultaneous coins, then cancel together with buy at credit 6.
    cyc(1'b1, 1'b1, 0, 1'b0, 1'b0); idle(1);
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0); idle(1);
    cyc(1'b0, 1'b0, 0, 1'b1, 1'b1); idle(14);

    // Reset in the middle of a 5-pulse return.
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b0); idle(1); cyc(1'b0, 1'b1, 0, 1'b0, 1'b0); idle(1);
    cyc(1'b0, 1'b0, 1, 1'b1, 1'b0);
    idle(3);
    chk("second_change_pulse", int'(bus.change), 1);
    do_reset();
    idle(12);

    // Randomised traffic including level-held inputs.
    for (int i = 0; i < 800; i++) begin
      cyc(1'($urandom_range(0, 99) < 18), 1'($urandom_range(0, 99) < 10),
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 99) < 12),
          1'($urandom_range(0, 99) < 4));
    end
    idle(40);

    running = 1'b0;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
